// File: rtl/cache_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_pipe_stage_if
// Brief    : Handshake and field bundle between the tag-compare stage, the
//            cache_pipe_stage register and the data/tag-array update stage.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_pipe_stage_if #(
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4,
    parameter int WORD_WIDTH   = 32,
    parameter int WAY_NUM      = 4
);
    localparam int c_BE_WIDTH = WORD_WIDTH / 8;

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_wr;
    logic [INDEX_WIDTH-1:0]  in_index;
    logic [OFFSET_WIDTH-1:0] in_offset;
    logic [WORD_WIDTH-1:0]   in_store_data;
    logic [c_BE_WIDTH-1:0]   in_byte_en;
    logic [WAY_NUM-1:0]      in_hit_en;
    logic [WAY_NUM-1:0]      in_replace_en;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_wr;
    logic [INDEX_WIDTH-1:0]  out_index;
    logic [OFFSET_WIDTH-1:0] out_offset;
    logic [WORD_WIDTH-1:0]   out_store_data;
    logic [c_BE_WIDTH-1:0]   out_byte_en;
    logic [WAY_NUM-1:0]      out_hit_en;
    logic [WAY_NUM-1:0]      out_replace_en;
    logic                    raw_hazard;
    logic                    err_onehot;

    // Environment side: drives requests and downstream ready.
    modport master (
        output flush, in_valid, in_wr, in_index, in_offset, in_store_data,
               in_byte_en, in_hit_en, in_replace_en, out_ready,
        input  in_ready, out_valid, out_wr, out_index, out_offset,
               out_store_data, out_byte_en, out_hit_en, out_replace_en,
               raw_hazard, err_onehot
    );

    // Pipeline-stage side.
    modport slave (
        input  flush, in_valid, in_wr, in_index, in_offset, in_store_data,
               in_byte_en, in_hit_en, in_replace_en, out_ready,
        output in_ready, out_valid, out_wr, out_index, out_offset,
               out_store_data, out_byte_en, out_hit_en, out_replace_en,
               raw_hazard, err_onehot
    );
endinterface
`default_nettype wire

// File: rtl/cache_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : cache_pipe_stage
// Brief    : Elastic head/skid pipeline register between cache tag compare
//            and array update, with flush, load-after-store hazard flag and
//            sticky replace-vector error flag.
// Revision : 1.0 - initial release
// ============================================================================
module cache_pipe_stage #(
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4,
    parameter int WORD_WIDTH   = 32,
    parameter int WAY_NUM      = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    cache_pipe_stage_if.slave    bus
);
    localparam int c_BE_WIDTH = WORD_WIDTH / 8;
    localparam int c_ENTRY_W  = 1 + INDEX_WIDTH + OFFSET_WIDTH + WORD_WIDTH
                              + c_BE_WIDTH + 2 * WAY_NUM;
    // Position of the index/offset fields just below the wr bit.
    localparam int c_IDX_MSB  = c_ENTRY_W - 2;
    localparam int c_OFF_MSB  = c_ENTRY_W - 2 - INDEX_WIDTH;
    localparam logic [WAY_NUM-1:0] c_WAY_ONE = {{(WAY_NUM-1){1'b0}}, 1'b1};

    logic                 r_h_valid;
    logic                 r_s_valid;
    logic [c_ENTRY_W-1:0] r_h_entry;
    logic [c_ENTRY_W-1:0] r_s_entry;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_bad_vec;
    logic                 w_h_match;
    logic                 w_s_match;
    logic [c_ENTRY_W-1:0] w_in_entry;

    assign w_in_entry = {bus.in_wr, bus.in_index, bus.in_offset, bus.in_store_data,
                         bus.in_byte_en, bus.in_hit_en, bus.in_replace_en};

    assign w_accept = bus.in_valid && !r_s_valid;
    assign w_pop    = r_h_valid && bus.out_ready;

    // More than one replace bit, or a replace request on a hit.
    assign w_bad_vec = ((bus.in_replace_en & (bus.in_replace_en - c_WAY_ONE)) != '0)
                     || ((|bus.in_hit_en) && (|bus.in_replace_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_h_entry <= '0;
            r_s_entry <= '0;
            r_err     <= 1'b0;
        end else if (bus.flush) begin
            r_h_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else begin
            if (w_accept && w_bad_vec) begin
                r_err <= 1'b1;
            end
            if (!r_h_valid || w_pop) begin
                // in_ready is low whenever S holds data, so no accept collides here.
                if (r_s_valid) begin
                    r_h_entry <= r_s_entry;
                    r_h_valid <= 1'b1;
                    r_s_valid <= 1'b0;
                end else if (w_accept) begin
                    r_h_entry <= w_in_entry;
                    r_h_valid <= 1'b1;
                end else begin
                    r_h_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_s_entry <= w_in_entry;
                r_s_valid <= 1'b1;
            end
        end
    end

    assign w_h_match = r_h_valid && r_h_entry[c_ENTRY_W-1]
                    && (r_h_entry[c_IDX_MSB -: INDEX_WIDTH]  == bus.in_index)
                    && (r_h_entry[c_OFF_MSB -: OFFSET_WIDTH] == bus.in_offset);
    assign w_s_match = r_s_valid && r_s_entry[c_ENTRY_W-1]
                    && (r_s_entry[c_IDX_MSB -: INDEX_WIDTH]  == bus.in_index)
                    && (r_s_entry[c_OFF_MSB -: OFFSET_WIDTH] == bus.in_offset);

    assign bus.raw_hazard = bus.in_valid && !bus.in_wr && (w_h_match || w_s_match);
    assign bus.in_ready   = !r_s_valid;
    assign bus.out_valid  = r_h_valid;
    assign bus.err_onehot = r_err;
    assign {bus.out_wr, bus.out_index, bus.out_offset, bus.out_store_data,
            bus.out_byte_en, bus.out_hit_en, bus.out_replace_en} = r_h_entry;

endmodule
`default_nettype wire

// File: tb/tb_cache_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_pipe_stage
// Brief    : Directed self-checking bench for cache_pipe_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_pipe_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    cache_pipe_stage_if #(.INDEX_WIDTH(6), .OFFSET_WIDTH(4), .WORD_WIDTH(32), .WAY_NUM(4)) bus ();

    cache_pipe_stage #(
        .INDEX_WIDTH (6),
        .OFFSET_WIDTH(4),
        .WORD_WIDTH  (32),
        .WAY_NUM     (4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [5:0] idx, input logic [3:0] off,
                        input logic [3:0] hit, input logic [3:0] repl);
        bus.in_valid      = 1'b1;
        bus.in_wr         = wr;
        bus.in_index      = idx;
        bus.in_offset     = off;
        bus.in_store_data = 32'hA5A5_0000 | {26'd0, idx};
        bus.in_byte_en    = wr ? 4'hF : 4'h0;
        bus.in_hit_en     = hit;
        bus.in_replace_en = repl;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_wr    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_wr = 1'b0;
        bus.in_index = '0;
        bus.in_offset = '0;
        bus.in_store_data = '0;
        bus.in_byte_en = '0;
        bus.in_hit_en = '0;
        bus.in_replace_en = '0;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_data", bus.out_store_data, 0);
        check("rst_hazard", bus.raw_hazard, 0);
        check("rst_err", bus.err_onehot, 0);
        #10 rst = 1'b0;

        // Streaming: eight loads back-to-back, each visible one edge later.
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 6'(i), 4'd0, 4'b0001, 4'b0000);
            step();
            check($sformatf("stream_idx%0d", i), bus.out_index, 64'(i));
            check($sformatf("stream_vld%0d", i), bus.out_valid, 1);
            check($sformatf("stream_rdy%0d", i), bus.in_ready, 1);
        end
        idle();
        step();
        check("stream_drain", bus.out_valid, 0);

        // Back-pressure: A in head, B in skid, C refused until release.
        bus.out_ready = 1'b0;
        send(1'b0, 6'd10, 4'd1, 4'b0000, 4'b0001);
        step();
        check("bp_A_head", bus.out_index, 10);
        check("bp_rdy_after_A", bus.in_ready, 1);
        send(1'b0, 6'd11, 4'd1, 4'b0000, 4'b0001);
        step();
        check("bp_rdy_after_B", bus.in_ready, 0);
        check("bp_A_held", bus.out_index, 10);
        send(1'b1, 6'd12, 4'd1, 4'b0000, 4'b0001);
        step();
        check("bp_C_refused", bus.in_ready, 0);
        check("bp_A_stable", bus.out_index, 10);
        bus.out_ready = 1'b1;
        step();
        check("bp_B_out", bus.out_index, 11);
        check("bp_rdy_reopen", bus.in_ready, 1);
        step();
        check("bp_C_out", bus.out_index, 12);
        check("bp_C_data", bus.out_store_data, 64'hA5A5_000C);
        check("bp_C_be", bus.out_byte_en, 4'hF);
        idle();
        step();
        check("bp_empty", bus.out_valid, 0);

        // Flush with both registers full and input presented.
        bus.out_ready = 1'b0;
        send(1'b0, 6'd20, 4'd0, 4'b0000, 4'b0000);
        step();
        send(1'b0, 6'd21, 4'd0, 4'b0000, 4'b0000);
        step();
        check("fl_full", bus.in_ready, 0);
        send(1'b0, 6'd22, 4'd0, 4'b0000, 4'b0000);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        idle();
        check("fl_out_valid", bus.out_valid, 0);
        check("fl_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        step();
        check("fl_no_ghost", bus.out_valid, 0);
        // Flush while in_ready is high still discards the input.
        bus.out_ready = 1'b0;
        send(1'b0, 6'd23, 4'd0, 4'b0000, 4'b0000);
        step();
        send(1'b0, 6'd24, 4'd0, 4'b0000, 4'b0000);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        idle();
        check("fl2_out_valid", bus.out_valid, 0);
        step();
        check("fl2_no_ghost", bus.out_valid, 0);

        // Hazard: store (5,3) held in head.
        send(1'b1, 6'd5, 4'd3, 4'b0000, 4'b0000);
        step();
        send(1'b0, 6'd5, 4'd3, 4'b0000, 4'b0000);
        #1 check("hz_match", bus.raw_hazard, 1);
        bus.in_offset = 4'd2;
        #1 check("hz_off_diff", bus.raw_hazard, 0);
        bus.in_offset = 4'd3;
        bus.in_wr = 1'b1;
        #1 check("hz_store", bus.raw_hazard, 0);
        idle();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;

        // Error: illegal replace vector, then legal traffic.
        bus.out_ready = 1'b1;
        check("err_clear", bus.err_onehot, 0);
        send(1'b0, 6'd1, 4'd0, 4'b0000, 4'b0110);
        step();
        check("err_set", bus.err_onehot, 1);
        check("err_repl_out", bus.out_replace_en, 4'b0110);
        send(1'b0, 6'd2, 4'd0, 4'b0000, 4'b0001);
        step();
        send(1'b0, 6'd3, 4'd0, 4'b0010, 4'b0000);
        step();
        check("err_sticky", bus.err_onehot, 1);

        // Async reset mid-stall with skid full.
        bus.out_ready = 1'b0;
        send(1'b1, 6'd30, 4'd7, 4'b0000, 4'b0001);
        step();
        send(1'b1, 6'd31, 4'd7, 4'b0000, 4'b0001);
        step();
        idle();
        check("ar_full", bus.in_ready, 0);
        #3 rst = 1'b1;
        #1;
        check("ar_out_valid", bus.out_valid, 0);
        check("ar_in_ready", bus.in_ready, 1);
        check("ar_out_index", bus.out_index, 0);
        check("ar_err", bus.err_onehot, 0);
        #3 rst = 1'b0;
        step();
        check("ar_ready_after", bus.in_ready, 1);
        check("ar_empty_after", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
